// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the 3-port NoC router (East, West, Local).
//   - Flit field positions: valid bit, destination, source id, sequence count.
//   - 2-bit port code type and the codes of the three router ports.
//   - nextPort(): round-robin successor E -> W -> L -> E.
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int VALID_BIT = 0;
  localparam int DST_LSB   = 1;
  localparam int SRC_LSB   = 3;
  localparam int CNT_LSB   = 5;

  typedef logic [1:0] port_t;

  localparam port_t PORT_E = 2'b00;
  localparam port_t PORT_W = 2'b01;
  localparam port_t PORT_L = 2'b10;

  // Successor in the round-robin ring. Code 11 is not a real port, so it
  // folds back to East rather than getting stuck.
  function automatic port_t nextPort(input port_t p);
    port_t n;
    case (p)
      PORT_E:  n = PORT_W;
      PORT_W:  n = PORT_L;
      default: n = PORT_E;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational three-way round-robin picker.
// Ports:
//   req [2:0]  requests, bit order {L,W,E}
//   ptr        port code that has highest priority this cycle
//   gnt [2:0]  one-hot grant {L,W,E}, zero when nothing requests
//   any        at least one request is present
// -----------------------------------------------------------------------------
module rr_pick3
  import noc_pkg::*;
(
  input  logic [2:0] req,
  input  port_t      ptr,
  output logic [2:0] gnt,
  output logic       any
);

  // Scan the requests starting at the pointer and walking E -> W -> L -> E.
  // The unused pointer code 11 is treated like East so the picker always
  // produces a legal grant.
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      PORT_W: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      PORT_L: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_port_arbiter
// Output-port scheduler, one instance per router output port. Watches the
// show-ahead heads of the E/W/L input FIFOs, picks flits addressed to PORT_ID
// in round-robin order, pops the winner and registers it towards the
// downstream FIFO. The instance with DROP_INVALID=1 also discards heads whose
// valid bit is clear.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     0 blocks all grants and drops
//   emptyE/W/L, headE/W/L      input FIFO status and head flits
//   downFull, downAlmostFull   downstream FIFO status
//   popE/W/L                   combinational FIFO read strobes
//   dataOut, writeOut          registered flit and write strobe
//   grant                      registered one-hot {L,W,E} of the last winner
// -----------------------------------------------------------------------------
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int    WIDTH        = 16,
  parameter port_t PORT_ID      = PORT_E,
  parameter bit    DROP_INVALID = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             emptyE,
  input  logic             emptyW,
  input  logic             emptyL,
  input  logic [WIDTH-1:0] headE,
  input  logic [WIDTH-1:0] headW,
  input  logic [WIDTH-1:0] headL,
  input  logic             downFull,
  input  logic             downAlmostFull,
  output logic             popE,
  output logic             popW,
  output logic             popL,
  output logic [WIDTH-1:0] dataOut,
  output logic             writeOut,
  output logic [2:0]       grant
);

  logic [2:0]       w_req;
  logic [2:0]       w_pick;
  logic             w_any;
  logic             w_stall;
  logic [2:0]       w_grant;
  logic [2:0]       w_drop;
  port_t            w_winner;
  logic [WIDTH-1:0] w_winData;

  port_t            r_ptr;
  logic [WIDTH-1:0] r_dataOut;
  logic             r_writeOut;
  logic [2:0]       r_grant;

  // A head requests this port when it is present, valid and addressed here.
  // Destination 11 never equals a real PORT_ID, so it is silently ignored.
  assign w_req[0] = enable & ~emptyE & headE[VALID_BIT] &
                    (headE[DST_LSB+1:DST_LSB] == PORT_ID);
  assign w_req[1] = enable & ~emptyW & headW[VALID_BIT] &
                    (headW[DST_LSB+1:DST_LSB] == PORT_ID);
  assign w_req[2] = enable & ~emptyL & headL[VALID_BIT] &
                    (headL[DST_LSB+1:DST_LSB] == PORT_ID);

  // A write registered now lands one edge later, so while a write is in
  // flight we must already back off on almost-full.
  assign w_stall = (r_writeOut & downAlmostFull) | (~r_writeOut & downFull);

  rr_pick3 u_pick (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_pick),
    .any (w_any)
  );

  assign w_grant = (w_any & ~w_stall) ? w_pick : 3'b000;

  // Invalid heads are flushed in fixed priority E > W > L, independently of
  // the downstream stall. A drop and a grant never target the same input
  // because one needs the valid bit clear and the other set.
  always_comb begin
    w_drop = 3'b000;
    if (DROP_INVALID && enable) begin
      if (~emptyE & ~headE[VALID_BIT])      w_drop = 3'b001;
      else if (~emptyW & ~headW[VALID_BIT]) w_drop = 3'b010;
      else if (~emptyL & ~headL[VALID_BIT]) w_drop = 3'b100;
    end
  end

  assign popE = ~reset & (w_grant[0] | w_drop[0]);
  assign popW = ~reset & (w_grant[1] | w_drop[1]);
  assign popL = ~reset & (w_grant[2] | w_drop[2]);

  // Translate the one-hot grant into a port code and the matching head flit.
  always_comb begin
    w_winner  = PORT_E;
    w_winData = headE;
    if (w_grant[1]) begin
      w_winner  = PORT_W;
      w_winData = headW;
    end else if (w_grant[2]) begin
      w_winner  = PORT_L;
      w_winData = headL;
    end
  end

  // Output register and round-robin pointer. On a grant the flit is latched
  // and the pointer moves just past the winner; otherwise the strobe drops,
  // the flit holds and the pointer keeps its place. Reset discards any flit
  // that was about to be written.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataOut  <= '0;
      r_writeOut <= 1'b0;
      r_grant    <= 3'b000;
      r_ptr      <= PORT_E;
    end else if (|w_grant) begin
      r_dataOut  <= w_winData;
      r_writeOut <= 1'b1;
      r_grant    <= w_grant;
      r_ptr      <= nextPort(w_winner);
    end else begin
      r_writeOut <= 1'b0;
      r_grant    <= 3'b000;
    end
  end

  assign dataOut  = r_dataOut;
  assign writeOut = r_writeOut;
  assign grant    = r_grant;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_port_arbiter
// Directed bench for noc_port_arbiter. Two instances share the input FIFO
// model: dutE serves East and drops invalid heads, dutL serves Local and
// never drops. Inputs change 1 time unit after a rising edge; pops are
// looked at once they settle, registered outputs 1 unit after an edge.
// -----------------------------------------------------------------------------
module tb_noc_port_arbiter;

  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        emptyE, emptyW, emptyL;
  logic [15:0] headE, headW, headL;
  logic        downFull, downAlmostFull;

  logic        popE_E, popW_E, popL_E, writeOut_E;
  logic [15:0] dataOut_E;
  logic [2:0]  grant_E;
  logic        popE_L, popW_L, popL_L, writeOut_L;
  logic [15:0] dataOut_L;
  logic [2:0]  grant_L;

  logic [2:0]  popsE, popsL;

  int vectors    = 0;
  int miscompares = 0;

  assign popsE = {popL_E, popW_E, popE_E};
  assign popsL = {popL_L, popW_L, popE_L};

  always #5 clk = ~clk;

  noc_port_arbiter #(.WIDTH(16), .PORT_ID(PORT_E), .DROP_INVALID(1'b1)) dutE (
    .clk(clk), .reset(reset), .enable(enable),
    .emptyE(emptyE), .emptyW(emptyW), .emptyL(emptyL),
    .headE(headE), .headW(headW), .headL(headL),
    .downFull(downFull), .downAlmostFull(downAlmostFull),
    .popE(popE_E), .popW(popW_E), .popL(popL_E),
    .dataOut(dataOut_E), .writeOut(writeOut_E), .grant(grant_E)
  );

  noc_port_arbiter #(.WIDTH(16), .PORT_ID(PORT_L), .DROP_INVALID(1'b0)) dutL (
    .clk(clk), .reset(reset), .enable(enable),
    .emptyE(emptyE), .emptyW(emptyW), .emptyL(emptyL),
    .headE(headE), .headW(headW), .headL(headL),
    .downFull(downFull), .downAlmostFull(downAlmostFull),
    .popE(popE_L), .popW(popW_L), .popL(popL_L),
    .dataOut(dataOut_L), .writeOut(writeOut_L), .grant(grant_L)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the three input FIFO views and let the combinational pops settle.
  task automatic applyStimulus(input logic eE, input logic eW, input logic eL,
                               input logic [15:0] hE, input logic [15:0] hW,
                               input logic [15:0] hL);
    emptyE = eE; emptyW = eW; emptyL = eL;
    headE  = hE; headW  = hW; headL  = hL;
    #1;
  endtask

  // Reset held for two cycles with every FIFO non-empty: no pops at any
  // point, and all registered outputs cleared afterwards.
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; downFull = 1'b0; downAlmostFull = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0015, 16'h0031);
    for (int c = 0; c < 2; c++) begin
      vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL reset_popsE cyc %0d got %b want 000", c, popsE); miscompares++; end
      vectors++; if (popsL !== 3'b000) begin $display("[TB] FAIL reset_popsL cyc %0d got %b want 000", c, popsL); miscompares++; end
      tick();
    end
    vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL reset_popsE_end got %b want 000", popsE); miscompares++; end
    vectors++; if (dataOut_E !== 16'h0000) begin $display("[TB] FAIL reset_data got %h want 0000", dataOut_E); miscompares++; end
    vectors++; if (writeOut_E !== 1'b0) begin $display("[TB] FAIL reset_write got %b want 0", writeOut_E); miscompares++; end
    vectors++; if (grant_E !== 3'b000) begin $display("[TB] FAIL reset_grant got %b want 000", grant_E); miscompares++; end
    vectors++; if (grant_L !== 3'b000) begin $display("[TB] FAIL reset_grantL got %b want 000", grant_L); miscompares++; end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    reset = 1'b0;
    tick();
  endtask

  // Only West holds a flit for Local: popW now, flit out one cycle later.
  task automatic test_single();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0015, 16'h0000);
    vectors++; if (popsL !== 3'b010) begin $display("[TB] FAIL single_pop got %b want 010", popsL); miscompares++; end
    vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL single_popE got %b want 000", popsE); miscompares++; end
    tick();
    vectors++; if (dataOut_L !== 16'h0015) begin $display("[TB] FAIL single_data got %h want 0015", dataOut_L); miscompares++; end
    vectors++; if (writeOut_L !== 1'b1) begin $display("[TB] FAIL single_write got %b want 1", writeOut_L); miscompares++; end
    vectors++; if (grant_L !== 3'b010) begin $display("[TB] FAIL single_grant got %b want 010", grant_L); miscompares++; end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    tick();
    vectors++; if (writeOut_L !== 1'b0) begin $display("[TB] FAIL single_idle_write got %b want 0", writeOut_L); miscompares++; end
    vectors++; if (dataOut_L !== 16'h0015) begin $display("[TB] FAIL single_hold got %h want 0015", dataOut_L); miscompares++; end
  endtask

  // All three heads target East continuously: strict E,W,L rotation.
  task automatic test_round_robin();
    logic [2:0]  expGnt [3];
    logic [15:0] expData [3];
    expGnt[0] = 3'b001; expGnt[1] = 3'b010; expGnt[2] = 3'b100;
    expData[0] = 16'h0021; expData[1] = 16'h0029; expData[2] = 16'h0031;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0029, 16'h0031);
    for (int i = 0; i < 6; i++) begin
      vectors++; if (popsE !== expGnt[i%3]) begin $display("[TB] FAIL rr_pop step %0d got %b want %b", i, popsE, expGnt[i%3]); miscompares++; end
      tick();
      vectors++; if (grant_E !== expGnt[i%3]) begin $display("[TB] FAIL rr_grant step %0d got %b want %b", i, grant_E, expGnt[i%3]); miscompares++; end
      vectors++; if (dataOut_E !== expData[i%3]) begin $display("[TB] FAIL rr_data step %0d got %h want %h", i, dataOut_E, expData[i%3]); miscompares++; end
      vectors++; if (writeOut_E !== 1'b1) begin $display("[TB] FAIL rr_write step %0d got %b want 1", i, writeOut_E); miscompares++; end
    end
  endtask

  // Almost-full with a write in flight, then full with none: both stall.
  // On release the pointer (still at E) decides the next winners.
  task automatic test_backpressure();
    downAlmostFull = 1'b1;
    #1;
    vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL bp_af_pop got %b want 000", popsE); miscompares++; end
    tick();
    vectors++; if (writeOut_E !== 1'b0) begin $display("[TB] FAIL bp_af_write got %b want 0", writeOut_E); miscompares++; end
    vectors++; if (grant_E !== 3'b000) begin $display("[TB] FAIL bp_af_grant got %b want 000", grant_E); miscompares++; end
    downAlmostFull = 1'b0; downFull = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL bp_full_pop cyc %0d got %b want 000", c, popsE); miscompares++; end
      tick();
      vectors++; if (writeOut_E !== 1'b0) begin $display("[TB] FAIL bp_full_write cyc %0d got %b want 0", c, writeOut_E); miscompares++; end
    end
    downFull = 1'b0;
    #1;
    vectors++; if (popsE !== 3'b001) begin $display("[TB] FAIL bp_release_pop got %b want 001", popsE); miscompares++; end
    tick();
    vectors++; if (grant_E !== 3'b001) begin $display("[TB] FAIL bp_release_grant got %b want 001", grant_E); miscompares++; end
    vectors++; if (dataOut_E !== 16'h0021) begin $display("[TB] FAIL bp_release_data got %h want 0021", dataOut_E); miscompares++; end
    vectors++; if (popsE !== 3'b010) begin $display("[TB] FAIL bp_next_pop got %b want 010", popsE); miscompares++; end
    tick();
    vectors++; if (grant_E !== 3'b010) begin $display("[TB] FAIL bp_next_grant got %b want 010", grant_E); miscompares++; end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    tick();
  endtask

  // Heads for West and for the unused code 11 must never be taken by East.
  task automatic test_dest_filter();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0007);
    for (int c = 0; c < 10; c++) begin
      vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL filter_pop cyc %0d got %b want 000", c, popsE); miscompares++; end
      tick();
      vectors++; if (writeOut_E !== 1'b0) begin $display("[TB] FAIL filter_write cyc %0d got %b want 0", c, writeOut_E); miscompares++; end
    end
    vectors++; if (popsL !== 3'b000) begin $display("[TB] FAIL filter_popL got %b want 000", popsL); miscompares++; end
  endtask

  // Invalid East head is dropped even while stalled; pointer (at L) must
  // not move, so on release L beats W while the drop continues on E.
  task automatic test_drop();
    downFull = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0009, 16'h0000);
    vectors++; if (popsE !== 3'b001) begin $display("[TB] FAIL drop_pop got %b want 001", popsE); miscompares++; end
    vectors++; if (popsL !== 3'b000) begin $display("[TB] FAIL drop_nodrop_inst got %b want 000", popsL); miscompares++; end
    tick();
    vectors++; if (writeOut_E !== 1'b0) begin $display("[TB] FAIL drop_write got %b want 0", writeOut_E); miscompares++; end
    downFull = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0009, 16'h0031);
    vectors++; if (popsE !== 3'b101) begin $display("[TB] FAIL drop_ptr_pop got %b want 101", popsE); miscompares++; end
    tick();
    vectors++; if (grant_E !== 3'b100) begin $display("[TB] FAIL drop_ptr_grant got %b want 100", grant_E); miscompares++; end
    vectors++; if (dataOut_E !== 16'h0031) begin $display("[TB] FAIL drop_ptr_data got %h want 0031", dataOut_E); miscompares++; end
  endtask

  // Disable with a flit already registered: it stays, nothing new starts.
  task automatic test_enable();
    enable = 1'b0;
    #1;
    vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL en_pop got %b want 000", popsE); miscompares++; end
    vectors++; if (writeOut_E !== 1'b1) begin $display("[TB] FAIL en_inflight got %b want 1", writeOut_E); miscompares++; end
    tick();
    vectors++; if (writeOut_E !== 1'b0) begin $display("[TB] FAIL en_write got %b want 0", writeOut_E); miscompares++; end
    vectors++; if (dataOut_E !== 16'h0031) begin $display("[TB] FAIL en_hold got %h want 0031", dataOut_E); miscompares++; end
  endtask

  // Reset with a registered flit pending discards it.
  task automatic test_midstream_reset();
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0029, 16'h0031);
    vectors++; if (popsE !== 3'b001) begin $display("[TB] FAIL mr_pop got %b want 001", popsE); miscompares++; end
    tick();
    vectors++; if (writeOut_E !== 1'b1) begin $display("[TB] FAIL mr_write got %b want 1", writeOut_E); miscompares++; end
    reset = 1'b1;
    #1;
    vectors++; if (popsE !== 3'b000) begin $display("[TB] FAIL mr_pop_rst got %b want 000", popsE); miscompares++; end
    tick();
    vectors++; if (writeOut_E !== 1'b0) begin $display("[TB] FAIL mr_write_rst got %b want 0", writeOut_E); miscompares++; end
    vectors++; if (dataOut_E !== 16'h0000) begin $display("[TB] FAIL mr_data_rst got %h want 0000", dataOut_E); miscompares++; end
    vectors++; if (grant_E !== 3'b000) begin $display("[TB] FAIL mr_grant_rst got %b want 000", grant_E); miscompares++; end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_dest_filter();
    test_drop();
    test_enable();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
